// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: coin credit, selection validation against price
// and stock, dispense handshake, and unit-by-unit change/refund payout.
module vend_txn_ctrl #(
    parameter int INIT_STOCK = 4,
    parameter int CREDIT_MAX = 6,
    parameter int TIMEOUT    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_vld,
    input  logic [1:0] coin,
    input  logic       sel_vld,
    input  logic [1:0] choice,
    input  logic       cancel,
    input  logic       restock,
    input  logic       disp_ack,
    output logic       disp_req,
    output logic [1:0] disp_prd,
    output logic       chg_pulse,
    output logic       coin_rej,
    output logic       sold_out,
    output logic       short_fund,
    output logic       busy,
    output logic [3:0] credit
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_CHANGE
    } state_t;

    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMR_END   = TW'(TIMEOUT);
    localparam logic [4:0]     CMAX      = 5'(CREDIT_MAX);
    localparam logic [3:0]     SLOT_INIT = 4'(INIT_STOCK);

    state_t        state_q, state_d;
    // rem_q counts pulses still owed after the one currently on chg_pulse.
    logic [3:0]    rem_q, rem_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    stock_q [4];
    logic [3:0]    stock_d [4];

    logic [3:0] credit_d;
    logic [1:0] prd_d;
    logic       chg_d, rej_d, sold_d, short_d;
    logic [1:0] coin_units;
    logic [4:0] credit_sum;
    logic [2:0] price;
    logic       coin_ok, refund;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        tmr_d    = tmr_q;
        stock_d  = stock_q;
        credit_d = credit;
        prd_d    = disp_prd;
        chg_d    = 1'b0;
        rej_d    = coin_vld;
        sold_d   = 1'b0;
        short_d  = 1'b0;
        coin_ok  = 1'b0;
        refund   = 1'b0;

        coin_units = (coin == 2'b01) ? 2'd1 : (coin == 2'b10) ? 2'd2 : 2'd0;
        credit_sum = {1'b0, credit} + {3'b000, coin_units};
        price      = {1'b0, choice} + 3'd1;

        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (state_q == S_COLLECT)
                    tmr_d = tmr_q + 1'b1;

                if (restock && state_q == S_IDLE && stock_q[choice] != 4'hF)
                    stock_d[choice] = stock_q[choice] + 4'd1;

                if (cancel) begin
                    refund = (state_q == S_COLLECT);
                end else begin
                    coin_ok = coin_vld && (coin_units != 2'd0) && (credit_sum <= CMAX);
                    if (coin_ok) begin
                        rej_d    = 1'b0;
                        credit_d = credit_sum[3:0];
                        state_d  = S_COLLECT;
                        tmr_d    = '0;
                    end

                    if (sel_vld) begin
                        tmr_d = '0;
                        // A coin or an IDLE restock in the same cycle swallows the selection.
                        if (!coin_vld && !(restock && state_q == S_IDLE)) begin
                            if (stock_q[choice] == 4'd0) begin
                                sold_d = 1'b1;
                            end else if (credit < {1'b0, price}) begin
                                short_d = 1'b1;
                            end else begin
                                prd_d           = choice;
                                rem_d           = credit - {1'b0, price};
                                stock_d[choice] = stock_q[choice] - 4'd1;
                                credit_d        = 4'd0;
                                state_d         = S_VEND;
                            end
                        end
                    end

                    if (state_q == S_COLLECT && !coin_ok && !sel_vld && tmr_q == TMR_END)
                        refund = 1'b1;
                end

                if (refund) begin
                    state_d  = S_CHANGE;
                    chg_d    = 1'b1;
                    rem_d    = credit - 4'd1;
                    credit_d = 4'd0;
                    tmr_d    = '0;
                end
            end

            S_VEND: begin
                if (disp_ack) begin
                    if (rem_q != 4'd0) begin
                        state_d = S_CHANGE;
                        chg_d   = 1'b1;
                        rem_d   = rem_q - 4'd1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_CHANGE: begin
                if (rem_q != 4'd0) begin
                    chg_d = 1'b1;
                    rem_d = rem_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the stock slots are a handful of flops, so they are reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            tmr_q      <= '0;
            for (int i = 0; i < 4; i++)
                stock_q[i] <= SLOT_INIT;
            credit     <= '0;
            disp_prd   <= '0;
            disp_req   <= 1'b0;
            chg_pulse  <= 1'b0;
            coin_rej   <= 1'b0;
            sold_out   <= 1'b0;
            short_fund <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            tmr_q      <= tmr_d;
            stock_q    <= stock_d;
            credit     <= credit_d;
            disp_prd   <= prd_d;
            disp_req   <= (state_d == S_VEND);
            chg_pulse  <= chg_d;
            coin_rej   <= rej_d;
            sold_out   <= sold_d;
            short_fund <= short_d;
            busy       <= (state_d == S_VEND) || (state_d == S_CHANGE);
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: purchases, change, refunds, stock limits and reset.
module tb_vend_txn_ctrl;

    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_vld = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_vld = 1'b0;
    logic [1:0] choice = 2'd0;
    logic       cancel = 1'b0;
    logic       restock = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [1:0] disp_prd;
    logic       chg_pulse;
    logic       coin_rej;
    logic       sold_out;
    logic       short_fund;
    logic       busy;
    logic [3:0] credit;

    int tests_run    = 0;
    int tests_failed = 0;

    vend_txn_ctrl #(
        .INIT_STOCK(4),
        .CREDIT_MAX(6),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .coin_vld  (coin_vld),
        .coin      (coin),
        .sel_vld   (sel_vld),
        .choice    (choice),
        .cancel    (cancel),
        .restock   (restock),
        .disp_ack  (disp_ack),
        .disp_req  (disp_req),
        .disp_prd  (disp_prd),
        .chg_pulse (chg_pulse),
        .coin_rej  (coin_rej),
        .sold_out  (sold_out),
        .short_fund(short_fund),
        .busy      (busy),
        .credit    (credit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [1:0] c);
        coin_vld = 1'b1;
        coin     = c;
        tick();
        coin_vld = 1'b0;
        coin     = 2'b00;
    endtask

    task automatic select(input logic [1:0] ch);
        sel_vld = 1'b1;
        choice  = ch;
        tick();
        sel_vld = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic do_ack();
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
    endtask

    // Counts change pulses from the current cycle until busy drops, bounded.
    task automatic drain(input string tag, output int n);
        logic done;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (chg_pulse) n++;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s_drain_timeout: busy still %0d after 40 cycles, want 0", tag, busy);
        end
    endtask

    // One Rs.10 purchase attempt; a failed selection is cancelled and refunded.
    task automatic buy(input logic [1:0] ch, output logic got_req, output logic got_sold);
        int n;
        insert(2'b10);
        select(ch);
        got_req  = disp_req;
        got_sold = sold_out;
        if (disp_req) do_ack();
        else          do_cancel();
        drain("buy", n);
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if ({disp_req, disp_prd, chg_pulse, coin_rej, sold_out, short_fund, busy, credit} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, want all 0",
                     {disp_req, disp_prd, chg_pulse, coin_rej, sold_out, short_fund, busy, credit});
        end
        #2 rst = 1'b0;
        tick();
        tests_run++;
        if ({disp_req, chg_pulse, busy, credit} !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b, want 0", {disp_req, chg_pulse, busy, credit});
        end
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        tests_run++;
        if ({disp_req, chg_pulse, busy} !== 3'd0) begin
            tests_failed++;
            $display("FAIL stray_ack_idle: got %b, want 000", {disp_req, chg_pulse, busy});
        end
    endtask

    task automatic test_change_one();
        int n;
        insert(2'b10);
        tests_run++;
        if (credit !== 4'd2) begin tests_failed++; $display("FAIL c1_credit: got %0d want 2", credit); end
        select(2'd0);
        tests_run++;
        if (disp_req !== 1'b1 || disp_prd !== 2'd0 || busy !== 1'b1 || credit !== 4'd0) begin
            tests_failed++;
            $display("FAIL c1_vend: req=%0d prd=%0d busy=%0d credit=%0d want 1 0 1 0", disp_req, disp_prd, busy, credit);
        end
        insert(2'b01);
        tests_run++;
        if (coin_rej !== 1'b1 || disp_req !== 1'b1 || credit !== 4'd0) begin
            tests_failed++;
            $display("FAIL c1_coin_in_vend: rej=%0d req=%0d credit=%0d want 1 1 0", coin_rej, disp_req, credit);
        end
        do_ack();
        tests_run++;
        if (disp_req !== 1'b0 || chg_pulse !== 1'b1) begin
            tests_failed++;
            $display("FAIL c1_ack: req=%0d chg=%0d want 0 1", disp_req, chg_pulse);
        end
        drain("c1", n);
        tests_run++;
        if (n !== 1 || credit !== 4'd0) begin
            tests_failed++;
            $display("FAIL c1_change: pulses=%0d credit=%0d want 1 0", n, credit);
        end
    endtask

    task automatic test_exact_fund();
        int n;
        insert(2'b01);
        insert(2'b10);
        tests_run++;
        if (credit !== 4'd3) begin tests_failed++; $display("FAIL ex_credit: got %0d want 3", credit); end
        select(2'd2);
        tests_run++;
        if (disp_req !== 1'b1 || disp_prd !== 2'd2) begin
            tests_failed++;
            $display("FAIL ex_vend: req=%0d prd=%0d want 1 2", disp_req, disp_prd);
        end
        tick();
        tests_run++;
        if (disp_req !== 1'b1) begin tests_failed++; $display("FAIL ex_req_held: got %0d want 1", disp_req); end
        do_ack();
        tests_run++;
        if (disp_req !== 1'b0 || chg_pulse !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ex_ack: req=%0d chg=%0d busy=%0d want 0 0 0", disp_req, chg_pulse, busy);
        end
        drain("ex", n);
        tests_run++;
        if (n !== 0 || credit !== 4'd0) begin
            tests_failed++;
            $display("FAIL ex_change: pulses=%0d credit=%0d want 0 0", n, credit);
        end
    endtask

    task automatic test_short_fund_cancel();
        int n;
        insert(2'b01);
        select(2'd3);
        tests_run++;
        if (short_fund !== 1'b1 || credit !== 4'd1 || disp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL sf_pulse: sf=%0d credit=%0d req=%0d want 1 1 0", short_fund, credit, disp_req);
        end
        tick();
        tests_run++;
        if (short_fund !== 1'b0) begin tests_failed++; $display("FAIL sf_one_cycle: got %0d want 0", short_fund); end
        do_cancel();
        tests_run++;
        if (chg_pulse !== 1'b1 || credit !== 4'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL sf_cancel: chg=%0d credit=%0d busy=%0d want 1 0 1", chg_pulse, credit, busy);
        end
        drain("sf", n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("FAIL sf_refund: pulses=%0d want 1", n); end
    endtask

    task automatic test_overflow_timeout();
        int n;
        int k;
        insert(2'b10);
        insert(2'b10);
        insert(2'b10);
        tests_run++;
        if (credit !== 4'd6) begin tests_failed++; $display("FAIL to_credit_max: got %0d want 6", credit); end
        insert(2'b01);
        tests_run++;
        if (coin_rej !== 1'b1 || credit !== 4'd6) begin
            tests_failed++;
            $display("FAIL to_overflow: rej=%0d credit=%0d want 1 6", coin_rej, credit);
        end
        tick();
        tests_run++;
        if (coin_rej !== 1'b0) begin tests_failed++; $display("FAIL to_rej_one_cycle: got %0d want 0", coin_rej); end
        k = 2;
        while (!chg_pulse && k < TIMEOUT + 10) begin
            tick();
            k++;
        end
        tests_run++;
        if (!chg_pulse || k < TIMEOUT || k > TIMEOUT + 2) begin
            tests_failed++;
            $display("FAIL to_latency: first pulse %0d cycles after last coin (seen=%0d), want %0d..%0d",
                     k, chg_pulse, TIMEOUT, TIMEOUT + 2);
        end
        drain("to", n);
        tests_run++;
        if (n !== 6 || credit !== 4'd0) begin
            tests_failed++;
            $display("FAIL to_refund: pulses=%0d credit=%0d want 6 0", n, credit);
        end
    endtask

    task automatic test_priority();
        int n;
        coin_vld = 1'b1; coin = 2'b10; sel_vld = 1'b1; choice = 2'd0;
        tick();
        coin_vld = 1'b0; coin = 2'b00; sel_vld = 1'b0;
        tests_run++;
        if (credit !== 4'd2 || disp_req !== 1'b0 || coin_rej !== 1'b0) begin
            tests_failed++;
            $display("FAIL pr_coin_sel: credit=%0d req=%0d rej=%0d want 2 0 0", credit, disp_req, coin_rej);
        end
        coin_vld = 1'b1; coin = 2'b01; cancel = 1'b1;
        tick();
        coin_vld = 1'b0; coin = 2'b00; cancel = 1'b0;
        tests_run++;
        if (coin_rej !== 1'b1 || chg_pulse !== 1'b1 || credit !== 4'd0) begin
            tests_failed++;
            $display("FAIL pr_cancel_coin: rej=%0d chg=%0d credit=%0d want 1 1 0", coin_rej, chg_pulse, credit);
        end
        drain("pr", n);
        tests_run++;
        if (n !== 2) begin tests_failed++; $display("FAIL pr_refund: pulses=%0d want 2", n); end
        insert(2'b11);
        tests_run++;
        if (coin_rej !== 1'b1 || credit !== 4'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL pr_invalid_coin: rej=%0d credit=%0d busy=%0d want 1 0 0", coin_rej, credit, busy);
        end
    endtask

    task automatic test_sold_out_restock();
        int   n;
        logic r, s;
        for (int i = 0; i < 4; i++) begin
            buy(2'd1, r, s);
            tests_run++;
            if (r !== 1'b1 || s !== 1'b0) begin
                tests_failed++;
                $display("FAIL so_buy%0d: req=%0d sold=%0d want 1 0", i, r, s);
            end
        end
        insert(2'b10);
        select(2'd1);
        tests_run++;
        if (sold_out !== 1'b1 || credit !== 4'd2 || disp_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL so_fifth: sold=%0d credit=%0d req=%0d want 1 2 0", sold_out, credit, disp_req);
        end
        do_cancel();
        drain("so", n);
        tests_run++;
        if (n !== 2) begin tests_failed++; $display("FAIL so_refund: pulses=%0d want 2", n); end
        restock = 1'b1; choice = 2'd1;
        tick();
        restock = 1'b0;
        buy(2'd1, r, s);
        tests_run++;
        if (r !== 1'b1 || s !== 1'b0) begin
            tests_failed++;
            $display("FAIL so_after_restock: req=%0d sold=%0d want 1 0", r, s);
        end
    endtask

    task automatic test_reset_midway();
        logic r, s;
        insert(2'b10);
        select(2'd0);
        tests_run++;
        if (disp_req !== 1'b1) begin tests_failed++; $display("FAIL rm_vend: req=%0d want 1", disp_req); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({disp_req, busy, chg_pulse, credit} !== 7'd0) begin
            tests_failed++;
            $display("FAIL rm_async_vend: got %b want 0", {disp_req, busy, chg_pulse, credit});
        end
        #2 rst = 1'b0;
        tick();
        insert(2'b10);
        insert(2'b10);
        insert(2'b10);
        do_cancel();
        tick();
        tests_run++;
        if (chg_pulse !== 1'b1) begin tests_failed++; $display("FAIL rm_pulsing: chg=%0d want 1", chg_pulse); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({chg_pulse, busy, credit, disp_req} !== 7'd0) begin
            tests_failed++;
            $display("FAIL rm_async_change: got %b want 0", {chg_pulse, busy, credit, disp_req});
        end
        #2 rst = 1'b0;
        tick();
        tests_run++;
        if (chg_pulse !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rm_no_change: chg=%0d busy=%0d want 0 0", chg_pulse, busy);
        end
        for (int i = 0; i < 4; i++) begin
            buy(2'd0, r, s);
            tests_run++;
            if (r !== 1'b1) begin tests_failed++; $display("FAIL rm_stock_buy%0d: req=%0d want 1", i, r); end
        end
        buy(2'd0, r, s);
        tests_run++;
        if (r !== 1'b0 || s !== 1'b1) begin
            tests_failed++;
            $display("FAIL rm_stock_empty: req=%0d sold=%0d want 0 1", r, s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_change_one();
        test_exact_fund();
        test_short_fund_cancel();
        test_overflow_timeout();
        test_priority();
        test_sold_out_restock();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction sequencer that sits in front of the vending datapath. It accepts Rs.5/Rs.10 coins, holds a credit count and a per-product stock count, and validates a product selection against price and stock. It then drives a dispense request/acknowledge handshake to the product dispenser and pays out change one Rs.5 unit per pulse. Cancel and inactivity timeout refund the full credit.

## Interface
- INIT_STOCK, 4, stock count loaded into every product slot at reset (0..15)
- CREDIT_MAX, 6, maximum credit in Rs.5 units (6 = Rs.30), 1..15
- TIMEOUT, 32, idle cycles in COLLECT before automatic refund, >= 2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- coin_vld  in  1  coin present this cycle
- coin  in  2  2'b01 = Rs.5, 2'b10 = Rs.10, 2'b00/2'b11 invalid
- sel_vld  in  1  selection strobe
- choice  in  2  product 0..3; prices Rs.5/10/15/20 = 1/2/3/4 units
- cancel  in  1  refund request
- restock  in  1  add 1 to stock[choice] (saturating at 15); honoured in IDLE only
- disp_ack  in  1  dispenser done
- disp_req  out  1  dispense request, held until ack
- disp_prd  out  2  product being dispensed, valid while disp_req
- chg_pulse  out  1  one Rs.5 unit of change returned this cycle
- coin_rej  out  1  one-cycle pulse: coin returned, not credited
- sold_out  out  1  one-cycle pulse: selected product has stock 0
- short_fund  out  1  one-cycle pulse: credit < price
- busy  out  1  high in VEND and CHANGE
- credit  out  4  current credit in Rs.5 units

## Operation
- States: IDLE (credit 0), COLLECT (credit > 0), VEND, CHANGE.
- Coin in IDLE/COLLECT: value v = 1 or 2 units. If credit + v <= CREDIT_MAX then credit += v and go to COLLECT, else coin_rej. Invalid code -> coin_rej. Coins in VEND/CHANGE -> coin_rej.
- Priority per cycle in IDLE/COLLECT: cancel > coin > sel. A coin together with cancel is rejected (coin_rej) and is not credited. A sel together with a coin is dropped silently.
- cancel in COLLECT -> CHANGE with remaining = credit. cancel in IDLE does nothing.
- sel_vld in IDLE/COLLECT, with p = choice + 1:
  - stock[choice] == 0 -> sold_out; state unchanged.
  - else credit < p -> short_fund; state unchanged.
  - else latch disp_prd = choice, remaining = credit - p, stock[choice] -= 1, credit cleared, then VEND.
- VEND: disp_req held high. On disp_ack go to CHANGE if remaining > 0, else IDLE. cancel, sel and restock are ignored.
- CHANGE: one chg_pulse per cycle and remaining -= 1. After the last pulse go to IDLE. Inputs are ignored except coin (rejected).
- Timeout: the counter resets on any accepted coin or on any sel_vld. It reaches TIMEOUT in COLLECT -> CHANGE with remaining = credit.
- restock in any state other than IDLE is ignored. restock together with sel_vld in IDLE: restock wins and sel is dropped.
- Credit never exceeds CREDIT_MAX and never wraps. remaining is at most CREDIT_MAX - 1.

## Timing
- Reset values: state IDLE, credit 0, remaining 0, timeout counter 0, every stock = INIT_STOCK. All outputs 0.
- Reset asserted mid-transaction aborts it immediately. Credit is lost, disp_req drops asynchronously, and no change is paid.
- All outputs are registered. Pulse outputs are high for exactly the one cycle after the triggering edge.
- Coin to credit update: 1 cycle.
- sel to disp_req: disp_req rises 1 cycle after the sel_vld edge.
- disp_ack sampled high -> disp_req low on the next edge. The first chg_pulse (if any) comes in that same cycle.
- Change of n units: n consecutive chg_pulse cycles, then IDLE with busy low in the following cycle.
- Refund via cancel or timeout: the first chg_pulse is 1 cycle after the cancel edge or after the counter hits TIMEOUT.
- disp_ack outside VEND is ignored.

## Test plan
- Rs.10 coin, then choice 0 -> credit 2; disp_req with disp_prd 0; after ack, exactly 1 chg_pulse; stock[0] = 3.
- Rs.5 + Rs.10, then choice 2 -> credit 3; dispense product 2 with 0 chg_pulse; back to IDLE, credit 0.
- Rs.5, then choice 3 -> short_fund pulse, credit stays 1. Then cancel -> 1 chg_pulse, IDLE.
- Three Rs.10 coins (credit 6), then a Rs.5 coin -> coin_rej and credit stays 6. Let TIMEOUT = 32 elapse -> 6 chg_pulse.
- Buy product 1 four times (Rs.10 each), then a fifth attempt -> sold_out pulse. restock with choice 1 in IDLE -> a further purchase succeeds.
- Assert rst while disp_req is high and while chg_pulse is active -> all outputs 0 immediately; stock back to INIT_STOCK.
